// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle between a data source and seg7_scan_driver: word to
// show, capture strobe, blanking mode, and the active-low segment/digit drives.
interface seg7_scan_driver_if;
   logic        cs;
   logic [31:0] i_data;
   logic        blank_lead;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;

   modport master (
      output cs,
      output i_data,
      output blank_lead,
      input  o_seg,
      input  o_sel
   );

   modport slave (
      input  cs,
      input  i_data,
      input  blank_lead,
      output o_seg,
      output o_sel
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a latched 32-bit word as 8 hex digits on a common-anode
// display, with per-slot dead time and optional leading-zero blanking.
module seg7_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter int DEAD     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   seg7_scan_driver_if.slave    bus
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

   logic [31:0]   latch_q, latch_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    sel_q, sel_d;

   logic       tick;
   logic       blanked;
   logic       zero_acc;
   logic [7:0] upper_zero;

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   always_comb begin
      latch_d = bus.cs ? bus.i_data : latch_q;

      tick  = (cnt_q == LAST_CNT);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      idx_d = tick ? idx_q + 3'd1 : idx_q;

      // upper_zero[k] is set when nibble k and every nibble above it are zero
      zero_acc   = 1'b1;
      upper_zero = '0;
      for (int k = 7; k >= 0; k--) begin
         zero_acc      = zero_acc && (latch_q[4*k +: 4] == 4'h0);
         upper_zero[k] = zero_acc;
      end

      blanked = bus.blank_lead && (idx_q != 3'd0) && upper_zero[idx_q];

      sel_d = 8'hFF;
      seg_d = 8'hFF;
      if (!(cnt_q < DEAD_CNT) && !blanked) begin
         sel_d = ~(8'b1 << idx_q);
         seg_d = hex_to_seg(latch_q[4*idx_q +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         latch_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 8'hFF;
         sel_q   <= 8'hFF;
      end else begin
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.o_seg = seg_q;
   assign bus.o_sel = sel_q;

endmodule
